regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//  Parametrised CPU register file: NUM_REGS x DATA_W storage, two read ports and one write port.
//  Select encoding: code 0 = hard-wired zero source; code k (1..NUM_REGS) = register k-1.
//  Provides optional write-to-read bypass, optional registered reads, and a sticky
//  out-of-range select flag. Sits between the decoder/controller and the ALU operand inputs.
// PARAMETERS
//  DATA_W    16  register and data-path width in bits
//  NUM_REGS  16  number of architectural registers (>=1)
//  SEL_W      5  select width; must satisfy 2**SEL_W >= NUM_REGS+1
//  BYPASS     1  1: a same-cycle write is forwarded to a matching read; 0: no forwarding
//  READ_LAT   0  0: combinational read; 1: read data registered (1-cycle latency)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  wr_en      in   1       write strobe, sampled on rising edge of clk
//  wr_sel     in   SEL_W   write select code (0 = discard)
//  wr_data    in   DATA_W  write data
//  rd_sel_a   in   SEL_W   read port A select code
//  rd_sel_b   in   SEL_W   read port B select code
//  rd_data_a  out  DATA_W  read port A data
//  rd_data_b  out  DATA_W  read port B data
//  sel_err    out  1       sticky: some select code exceeded NUM_REGS
//  err_clr    in   1       synchronous clear of sel_err
// BEHAVIOUR
//  Reset (async, any time incl. mid-write): all registers, registered read outputs, sel_err -> 0.
//   While reset high, writes are ignored; READ_LAT=0 outputs reflect the cleared (zero) registers.
//  Write: on rising edge of clk, if wr_en and 1<=wr_sel<=NUM_REGS then reg[wr_sel-1] <= wr_data.
//   wr_sel==0: write discarded, no error. wr_sel>NUM_REGS: write discarded, sel_err set.
//  Read decode (per port): sel==0 -> 0; 1..NUM_REGS -> reg[sel-1]; >NUM_REGS -> 0 (never X).
//  Bypass (BYPASS=1): if wr_en && wr_sel==rd_sel && 1<=wr_sel<=NUM_REGS, data = wr_data.
//   Both ports may bypass in the same cycle. BYPASS=0: read returns the pre-write value.
//  READ_LAT=0: rd_data_* are combinational from selects, storage, and bypass path.
//  READ_LAT=1: rd_data_* <= decoded(+bypassed) value on each edge; valid one cycle after select.
//   With BYPASS=1 the captured value equals the register contents after that edge's write.
//  sel_err: set on the edge where any of wr_sel (with wr_en), rd_sel_a, or rd_sel_b is >NUM_REGS.
//   Read selects are checked every cycle regardless of wr_en.
//   err_clr clears it on the edge; if set and clear occur together, set wins.
//  Arithmetic: no width growth; all data paths are exactly DATA_W. Select compares are unsigned, SEL_W wide.
//  No read-after-read hazards; ports are fully independent; A and B may select the same code.
// STRUCTURE
//  Shared package regfile_pkg:
//   default DATA_W/NUM_REGS; SEL_ZERO = 0 constant.
//   function sel_in_range(sel, n); function sel_width(n) = clog2(n+1).
//  Sub-module regfile_read_port: decode + bypass mux + optional output register.
//   Instantiated twice (A, B); each reports its own range error to the top.
//  Top holds the storage array, write decode, and the sel_err flop.
// TESTING
//  1 Reset: write 0xBEEF to code 3, then pulse reset -> code 3 reads 0x0000, sel_err=0, outputs 0.
//  2 Write/read: wr_sel=1 data 0x1234, wr_sel=16 data 0xA5A5 -> rd_sel_a=1 gives 0x1234, rd_sel_b=16 gives 0xA5A5.
//  3 Zero code: wr_sel=0 data 0xFFFF, then rd_sel_a=0 -> 0x0000; no register changed; sel_err=0.
//  4 Bypass: reg5 holds 0x0011; same cycle wr_sel=5 data 0x2222, rd_sel_a=rd_sel_b=5 -> BYPASS=1: both 0x2222
//    (READ_LAT=1: 0x2222 after the edge); BYPASS=0, READ_LAT=0: 0x0011 until the edge.
//  5 Range error: rd_sel_b=17 -> rd_data_b=0, sel_err=1 next edge; stays 1 until err_clr.
//    err_clr with rd_sel_a=20 in same cycle -> sel_err stays 1.
//  6 Async reset mid-op: assert reset between edges during wr_en=1 -> registers 0 immediately; write lost.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and select-code helpers for the 2R1W register file
package regfile_pkg;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;
  localparam int SEL_ZERO     = 0;
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return sel != SEL_ZERO && sel <= n;
  endfunction
  function automatic int sel_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: select decode, write bypass and optional output register for one read port
module regfile_read_port import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = sel_width(NUM_REGS),
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DATA_W-1:0] i_regs [NUM_REGS],
  input  logic              i_wr_act,
  input  logic [SEL_W-1:0]  i_wr_sel,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err
);
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_REGS);
  logic [DATA_W-1:0] w_dec, w_val, r_data;
  logic              w_byp;
  // code 0 and out-of-range codes match no register and fall through to zero
  always_comb begin
    w_dec = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (i_sel == SEL_W'(k + 1)) w_dec = i_regs[k];
  end
  assign w_byp = BYPASS != 0 && i_wr_act && i_wr_sel == i_sel;
  assign w_val = w_byp ? i_wr_data : w_dec;
  assign o_err = i_sel > MAX_SEL;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_data <= '0;
    else       r_data <= w_val;
  assign o_data = READ_LAT != 0 ? r_data : w_val;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NUM_REGS x DATA_W register file, two read ports, one write port, sticky select error
module regfile_2r1w import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = sel_width(NUM_REGS),
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  rd_sel_a,
  input  logic [SEL_W-1:0]  rd_sel_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              sel_err,
  input  logic              err_clr
);
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_REGS);
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_sel_err, w_wr_act, w_err_a, w_err_b, w_err_set;
  // reset also suppresses forwarding so combinational reads show cleared storage
  assign w_wr_act  = wr_en && !reset && sel_in_range(32'(wr_sel), NUM_REGS);
  assign w_err_set = (wr_en && wr_sel > MAX_SEL) || w_err_a || w_err_b;
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    else
      for (int k = 0; k < NUM_REGS; k++)
        if (w_wr_act && wr_sel == SEL_W'(k + 1)) r_regs[k] <= wr_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_sel_err <= 1'b0;
    else       r_sel_err <= w_err_set ? 1'b1 : err_clr ? 1'b0 : r_sel_err;
  assign sel_err = r_sel_err;
  regfile_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W),
                      .BYPASS(BYPASS), .READ_LAT(READ_LAT)) u_port_a (
    .clk(clk), .reset(reset), .i_sel(rd_sel_a), .i_regs(r_regs), .i_wr_act(w_wr_act),
    .i_wr_sel(wr_sel), .i_wr_data(wr_data), .o_data(rd_data_a), .o_err(w_err_a)
  );
  regfile_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W),
                      .BYPASS(BYPASS), .READ_LAT(READ_LAT)) u_port_b (
    .clk(clk), .reset(reset), .i_sel(rd_sel_b), .i_regs(r_regs), .i_wr_act(w_wr_act),
    .i_wr_sel(wr_sel), .i_wr_data(wr_data), .o_data(rd_data_b), .o_err(w_err_b)
  );
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: scenario tasks plus random traffic against an array-based register file model
module tb_regfile_2r1w;
  localparam int N = 16;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_sel = '0;
  logic [15:0] wr_data = '0;
  logic [4:0]  rd_sel_a = '0;
  logic [4:0]  rd_sel_b = '0;
  logic [15:0] rd_data_a, rd_data_b;
  logic        sel_err;
  logic        err_clr = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] model [N];
  logic        m_err;
  regfile_2r1w dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .sel_err(sel_err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  function automatic logic [15:0] expect_rd(input logic [4:0] sel);
    if (sel == 0 || sel > N) return 16'h0;
    if (!reset && wr_en && wr_sel == sel) return wr_data;
    return model[sel - 1];
  endfunction
  task automatic model_clear();
    for (int k = 0; k < N; k++) model[k] = '0;
    m_err = 1'b0;
  endtask
  task automatic tick();
    if (!reset) begin
      if (wr_en && wr_sel >= 1 && wr_sel <= N) model[wr_sel - 1] = wr_data;
      if ((wr_en && wr_sel > N) || rd_sel_a > N || rd_sel_b > N) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wr_en = 1'b1; wr_sel = 5'd3; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0; rd_sel_a = 5'd3; rd_sel_b = 5'd3;
    #1;
    total++; if (rd_data_a !== 16'hBEEF) begin bad++; $display("FAIL reset_pre got=%h exp=%h", rd_data_a, 16'hBEEF); end
    reset = 1'b1;
    #1;
    model_clear();
    total++; if (rd_data_a !== 16'h0) begin bad++; $display("FAIL reset_rd_a got=%h exp=0000", rd_data_a); end
    total++; if (rd_data_b !== 16'h0) begin bad++; $display("FAIL reset_rd_b got=%h exp=0000", rd_data_b); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", sel_err); end
    #1 reset = 1'b0;
    tick();
    total++; if (rd_data_a !== 16'h0) begin bad++; $display("FAIL reset_hold got=%h exp=0000", rd_data_a); end
  endtask
  task automatic test_write_read();
    wr_en = 1'b1; wr_sel = 5'd1; wr_data = 16'h1234;
    tick();
    wr_sel = 5'd16; wr_data = 16'hA5A5;
    tick();
    wr_en = 1'b0; rd_sel_a = 5'd1; rd_sel_b = 5'd16;
    #1;
    total++; if (rd_data_a !== 16'h1234) begin bad++; $display("FAIL wr_rd_a got=%h exp=1234", rd_data_a); end
    total++; if (rd_data_b !== 16'hA5A5) begin bad++; $display("FAIL wr_rd_b got=%h exp=a5a5", rd_data_b); end
  endtask
  task automatic test_zero_code();
    wr_en = 1'b1; wr_sel = 5'd0; wr_data = 16'hFFFF; rd_sel_a = 5'd0; rd_sel_b = 5'd1;
    #1;
    total++; if (rd_data_a !== 16'h0) begin bad++; $display("FAIL zero_byp got=%h exp=0000", rd_data_a); end
    tick();
    wr_en = 1'b0;
    #1;
    total++; if (rd_data_a !== 16'h0) begin bad++; $display("FAIL zero_rd got=%h exp=0000", rd_data_a); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL zero_err got=%b exp=0", sel_err); end
    for (int k = 1; k <= N; k++) begin
      rd_sel_b = 5'(k);
      #1;
      total++; if (rd_data_b !== model[k - 1]) begin bad++; $display("FAIL zero_scan r%0d got=%h exp=%h", k, rd_data_b, model[k - 1]); end
    end
  endtask
  task automatic test_bypass();
    wr_en = 1'b1; wr_sel = 5'd5; wr_data = 16'h0011;
    tick();
    wr_data = 16'h2222; rd_sel_a = 5'd5; rd_sel_b = 5'd5;
    #1;
    total++; if (rd_data_a !== 16'h2222) begin bad++; $display("FAIL byp_a got=%h exp=2222", rd_data_a); end
    total++; if (rd_data_b !== 16'h2222) begin bad++; $display("FAIL byp_b got=%h exp=2222", rd_data_b); end
    tick();
    wr_en = 1'b0;
    #1;
    total++; if (rd_data_a !== 16'h2222) begin bad++; $display("FAIL byp_after got=%h exp=2222", rd_data_a); end
  endtask
  task automatic test_range_error();
    rd_sel_a = 5'd2; rd_sel_b = 5'd17;
    #1;
    total++; if (rd_data_b !== 16'h0) begin bad++; $display("FAIL range_rd got=%h exp=0000", rd_data_b); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL range_early got=%b exp=0", sel_err); end
    tick();
    rd_sel_b = 5'd3;
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL range_set got=%b exp=1", sel_err); end
    tick(); tick();
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL range_sticky got=%b exp=1", sel_err); end
    err_clr = 1'b1; rd_sel_a = 5'd20;
    tick();
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL range_setwins got=%b exp=1", sel_err); end
    rd_sel_a = 5'd0;
    tick();
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL range_clr got=%b exp=0", sel_err); end
    err_clr = 1'b0; wr_en = 1'b1; wr_sel = 5'd31; wr_data = 16'hDEAD;
    tick();
    wr_en = 1'b0;
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL range_wr got=%b exp=1", sel_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++; if (sel_err !== m_err) begin bad++; $display("FAIL range_wrclr got=%b exp=%b", sel_err, m_err); end
  endtask
  task automatic test_async_reset();
    wr_en = 1'b1; wr_sel = 5'd7; wr_data = 16'h7777;
    tick();
    wr_data = 16'h1111; rd_sel_a = 5'd7; rd_sel_b = 5'd1;
    #1;
    total++; if (rd_data_a !== 16'h1111) begin bad++; $display("FAIL async_byp got=%h exp=1111", rd_data_a); end
    #1 reset = 1'b1;
    #1;
    model_clear();
    total++; if (rd_data_a !== 16'h0) begin bad++; $display("FAIL async_a got=%h exp=0000", rd_data_a); end
    total++; if (rd_data_b !== 16'h0) begin bad++; $display("FAIL async_b got=%h exp=0000", rd_data_b); end
    @(posedge clk);
    #1;
    total++; if (rd_data_a !== 16'h0) begin bad++; $display("FAIL async_hold got=%h exp=0000", rd_data_a); end
    reset = 1'b0; wr_en = 1'b0;
    #1;
    total++; if (rd_data_a !== 16'h0) begin bad++; $display("FAIL async_lost got=%h exp=0000", rd_data_a); end
    tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_en    = 1'($urandom_range(0, 3) != 0);
      wr_sel   = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, N));
      wr_data  = 16'($urandom);
      rd_sel_a = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, N));
      rd_sel_b = ($urandom_range(0, 3) == 0) ? wr_sel : 5'($urandom_range(0, N));
      err_clr  = 1'($urandom_range(0, 3) == 0);
      #1;
      total++; if (rd_data_a !== expect_rd(rd_sel_a)) begin bad++; $display("FAIL rand_a i=%0d sel=%0d got=%h exp=%h", i, rd_sel_a, rd_data_a, expect_rd(rd_sel_a)); end
      total++; if (rd_data_b !== expect_rd(rd_sel_b)) begin bad++; $display("FAIL rand_b i=%0d sel=%0d got=%h exp=%h", i, rd_sel_b, rd_data_b, expect_rd(rd_sel_b)); end
      total++; if (sel_err !== m_err) begin bad++; $display("FAIL rand_err i=%0d got=%b exp=%b", i, sel_err, m_err); end
      tick();
    end
    wr_en = 1'b0; err_clr = 1'b0;
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_zero_code();
    test_bypass();
    test_range_error();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
